// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller: MDOp codes,
// FSM state encoding and instruction class decode.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        BUSY      = 2'd2
    } md_state_t;

    function automatic logic is_start(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

    function automatic logic is_read(input logic [3:0] op);
        return (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Saturating BUSY-cycle counter; hit flags the cycle whose increment
// would bring the count to TIMEOUT.
module md_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT);

    logic [CW-1:0] cnt_r;
    logic [CW:0]   cnt_inc_s;

    // Next count and expiry compare.
    always_comb begin
        cnt_inc_s = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
        if (en && (cnt_inc_s >= LIMIT)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

    // Counter register: clear has priority, increment saturates at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_inc_s <= LIMIT)) begin
            cnt_r <= cnt_inc_s[CW-1:0];
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the MD unit: issues Start, tracks Busy,
// stalls md-class ops while the unit is occupied and muxes HI/LO out.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        EXValid,
    input  logic [3:0]  MDOp,
    input  logic [31:0] RS,
    input  logic [31:0] RT,
    input  logic        Busy,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic        Start,
    output logic [3:0]  MDSel,
    output logic [31:0] ALUOprand_A,
    output logic [31:0] ALUOprand_B,
    output logic        Stall,
    output logic [31:0] MDResult,
    output logic        Timeout
);

    md_state_t state_r;
    logic      timeout_r;
    logic      accept_s;
    logic      stall_s;
    logic      wd_clr_s;
    logic      wd_en_s;
    logic      wd_hit_s;

    md_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk (CLK),
        .rst (Reset),
        .clr (wd_clr_s),
        .en  (wd_en_s),
        .hit (wd_hit_s)
    );

    // Issue/stall decode; Stall follows the async-reset state so it drops with Reset.
    always_comb begin
        stall_s  = EXValid & (is_start(MDOp) | is_mt(MDOp) | is_read(MDOp))
                   & (state_r != IDLE);
        accept_s = EXValid & (is_start(MDOp) | is_mt(MDOp)) & ~stall_s;
        wd_clr_s = (state_r == WAIT_BUSY) & Busy;
        wd_en_s  = (state_r == BUSY);
        Stall    = stall_s;
        Start    = accept_s & ~Reset;
        Timeout  = timeout_r;
        ALUOprand_A = RS;
        ALUOprand_B = RT;
        if (is_start(MDOp) || is_mt(MDOp)) begin
            MDSel = MDOp;
        end else begin
            MDSel = MD_NONE;
        end
    end

    // HI/LO read mux.
    always_comb begin
        case (MDOp)
            MD_MFHI: MDResult = HI;
            MD_MFLO: MDResult = LO;
            default: MDResult = 32'd0;
        endcase
    end

    // Issue FSM and sticky watchdog flag.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            timeout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && is_start(MDOp)) begin
                        state_r <= WAIT_BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_BUSY: begin
                    state_r <= Busy ? BUSY : IDLE;
                end
                BUSY: begin
                    if (!Busy) begin
                        state_r <= IDLE;
                    end else if (wd_hit_s) begin
                        state_r   <= IDLE;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural MD unit model.
module tb_md_issue_ctrl;
    import md_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        EXValid;
    logic [3:0]  MDOp;
    logic [31:0] RS, RT;
    logic        Busy;
    logic [31:0] HI, LO;
    logic        Start;
    logic [3:0]  MDSel;
    logic [31:0] ALUOprand_A, ALUOprand_B;
    logic        Stall;
    logic [31:0] MDResult;
    logic        Timeout;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    logic busy_stuck = 1'b0;
    int starts;

    always #5 CLK = ~CLK;

    md_issue_ctrl #(.TIMEOUT(16)) dut (
        .CLK(CLK), .Reset(Reset), .EXValid(EXValid), .MDOp(MDOp),
        .RS(RS), .RT(RT), .Busy(Busy), .HI(HI), .LO(LO),
        .Start(Start), .MDSel(MDSel), .ALUOprand_A(ALUOprand_A),
        .ALUOprand_B(ALUOprand_B), .Stall(Stall), .MDResult(MDResult),
        .Timeout(Timeout)
    );

    // MD unit model: 5-cycle Busy for start-class ops, HI/LO written on Start.
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            busy_cnt <= 0;
            HI <= 32'd0;
            LO <= 32'd0;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (Start) begin
                case (MDSel)
                    4'd1, 4'd2: begin
                        {HI, LO} <= {32'd0, ALUOprand_A} * {32'd0, ALUOprand_B};
                        busy_cnt <= 5;
                    end
                    4'd3, 4'd4: begin
                        LO <= ALUOprand_A / ALUOprand_B;
                        HI <= ALUOprand_A % ALUOprand_B;
                        busy_cnt <= 5;
                    end
                    4'd5: HI <= ALUOprand_A;
                    4'd6: LO <= ALUOprand_A;
                    default: ;
                endcase
            end
        end
    end
    assign Busy = busy_stuck | (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs on the falling edge, leave time for combinational settle.
    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        EXValid = v; MDOp = op; RS = a; RT = b;
        #2;
    endtask

    initial begin
        Reset = 1'b1; EXValid = 1'b1; MDOp = MD_MULT; RS = 32'd1; RT = 32'd1;
        #2;
        chk("rst_start", {31'd0, Start}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_tmo", {31'd0, Timeout}, 32'd0);
        chk("rst_state", {30'd0, dut.state_r}, 32'd0);
        chk("rst_cnt", 32'(dut.u_wdog.cnt_r), 32'd0);
        @(negedge CLK);
        Reset = 1'b0; EXValid = 1'b0; MDOp = MD_NONE;

        // 1: MULT then MFLO stalls 6 cycles
        drive(1'b1, MD_MULT, 32'd25, 32'd2500);
        chk("t1_start", {31'd0, Start}, 32'd1);
        chk("t1_sel", {28'd0, MDSel}, 32'd1);
        chk("t1_a", ALUOprand_A, 32'd25);
        chk("t1_b", ALUOprand_B, 32'd2500);
        chk("t1_stall0", {31'd0, Stall}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, MD_MFLO, 32'd0, 32'd0);
            chk("t1_stall", {31'd0, Stall}, 32'd1);
            chk("t1_nostart", {31'd0, Start}, 32'd0);
        end
        drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        chk("t1_release", {31'd0, Stall}, 32'd0);
        chk("t1_lo", MDResult, 32'd62500);

        // 2: DIV directly behind MULT
        drive(1'b1, MD_MULT, 32'd7, 32'd6);
        chk("t2_mult", {31'd0, Start}, 32'd1);
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, MD_DIV, 32'd100, 32'd7);
            chk("t2_stall", {31'd0, Stall}, 32'd1);
            starts += int'(Start);
        end
        chk("t2_no_early_start", 32'(starts), 32'd0);
        drive(1'b1, MD_DIV, 32'd100, 32'd7);
        chk("t2_start", {31'd0, Start}, 32'd1);
        chk("t2_sel", {28'd0, MDSel}, 32'd3);
        chk("t2_stall0", {31'd0, Stall}, 32'd0);

        // 4: non-MD and bubbles during BUSY are never stalled
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        chk("t2_single", {31'd0, Start}, 32'd0);
        drive(1'b1, MD_NONE, 32'd0, 32'd0);
        chk("t4_busy", {30'd0, dut.state_r}, 32'd2);
        chk("t4_add", {31'd0, Stall}, 32'd0);
        drive(1'b0, MD_MFHI, 32'd0, 32'd0);
        chk("t4_bub_stall", {31'd0, Stall}, 32'd0);
        chk("t4_bub_start", {31'd0, Start}, 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, MD_NONE, 32'd0, 32'd0);
        drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        chk("t2_q_stall", {31'd0, Stall}, 32'd0);
        chk("t2_q", MDResult, 32'd14);
        drive(1'b1, MD_MFHI, 32'd0, 32'd0);
        chk("t2_r", MDResult, 32'd2);

        // 3: MTHI then MFHI
        drive(1'b1, MD_MTHI, 32'h1234, 32'd0);
        chk("t3_start", {31'd0, Start}, 32'd1);
        chk("t3_sel", {28'd0, MDSel}, 32'd5);
        chk("t3_stall", {31'd0, Stall}, 32'd0);
        drive(1'b1, MD_MFHI, 32'd0, 32'd0);
        chk("t3_rd_stall", {31'd0, Stall}, 32'd0);
        chk("t3_rd_start", {31'd0, Start}, 32'd0);
        chk("t3_hi", MDResult, 32'h1234);
        chk("t3_idle", {30'd0, dut.state_r}, 32'd0);

        // 5: Reset mid-BUSY
        drive(1'b1, MD_MULT, 32'd3, 32'd4);
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        chk("t5_stall_pre", {31'd0, Stall}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("t5_stall", {31'd0, Stall}, 32'd0);
        chk("t5_state", {30'd0, dut.state_r}, 32'd0);
        chk("t5_cnt", 32'(dut.u_wdog.cnt_r), 32'd0);
        drive(1'b1, MD_MULT, 32'd3, 32'd4);
        chk("t5_rst_start", {31'd0, Start}, 32'd0);
        Reset = 1'b0;
        #1;
        chk("t5_reissue", {31'd0, Start}, 32'd1);
        for (int i = 0; i < 6; i++) drive(1'b0, MD_NONE, 32'd0, 32'd0);
        drive(1'b1, MD_MFLO, 32'd0, 32'd0);
        chk("t5_lo", MDResult, 32'd12);

        // 6: Busy stuck high -> watchdog after 16 BUSY cycles
        busy_stuck = 1'b1;
        drive(1'b1, MD_MULT, 32'd1, 32'd1);
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, MD_NONE, 32'd0, 32'd0);
            if (i == 15) begin
                chk("t6_still_busy", {30'd0, dut.state_r}, 32'd2);
                chk("t6_cnt15", 32'(dut.u_wdog.cnt_r), 32'd15);
                chk("t6_no_tmo", {31'd0, Timeout}, 32'd0);
            end
        end
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        chk("t6_tmo", {31'd0, Timeout}, 32'd1);
        chk("t6_idle", {30'd0, dut.state_r}, 32'd0);
        busy_stuck = 1'b0;
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        chk("t6_sticky", {31'd0, Timeout}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("t6_clr", {31'd0, Timeout}, 32'd0);
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
